// File: rtl/key_evt_pkg.sv
// Shared types and default timing constants for the key event generator.
package key_evt_pkg;

  localparam int unsigned CNT_W_DEF     = 11;
  localparam int unsigned LONG_MS_DEF   = 1000;
  localparam int unsigned REPEAT_MS_DEF = 200;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_LONG = 2'd2
  } key_state_e;

  // Registered event bundle presented to the game FSM.
  typedef struct packed {
    logic press;
    logic rel;
    logic click;
    logic long_press;
    logic rpt;
    logic held;
  } key_evt_t;

endpackage

// File: rtl/key_event_gen_if.sv
// Key level in / key events out between the debouncer, key_event_gen and the game FSM.
interface key_event_gen_if;

  logic KEY_LVL;
  logic PRESS_PULSE;
  logic RELEASE_PULSE;
  logic CLICK_PULSE;
  logic LONG_PRESS;
  logic REPEAT_PULSE;
  logic HELD;

  modport master (
    input  KEY_LVL,
    output PRESS_PULSE, RELEASE_PULSE, CLICK_PULSE, LONG_PRESS, REPEAT_PULSE, HELD
  );

  modport slave (
    output KEY_LVL,
    input  PRESS_PULSE, RELEASE_PULSE, CLICK_PULSE, LONG_PRESS, REPEAT_PULSE, HELD
  );

endinterface

// File: rtl/key_evt_timer.sv
// Clearable/loadable up-counter with a combinational terminal-count compare.
module key_evt_timer #(
  parameter int unsigned CNT_W = 11,
  parameter int unsigned TERM  = 1000
) (
  input  logic CLK1K,
  input  logic RST,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic term_c
);

  logic [CNT_W-1:0] cnt;

  // clr beats load beats inc; load value is 1 because the loading edge is itself the first counted ms
  always_ff @(posedge CLK1K or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(1);
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign term_c = (cnt == CNT_W'(TERM));

endmodule

// File: rtl/key_event_gen.sv
// Turns the debounced key level into press/release/click/long/repeat pulses plus a HELD level.
module key_event_gen
  import key_evt_pkg::*;
#(
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned LONG_MS    = LONG_MS_DEF,
  parameter int unsigned REPEAT_MS  = REPEAT_MS_DEF,
  parameter bit          REPEAT_EN  = 1'b1,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             CLK1K,
  input  logic             RST,
  key_event_gen_if.master  kif
);

  key_state_e state;
  key_evt_t   evt_q;

  logic pressed_c;
  logic hold_term_c, rep_term_c;
  logic hold_clr_c, hold_ld_c, hold_inc_c;
  logic rep_clr_c, rep_ld_c, rep_inc_c;

  assign pressed_c = kif.KEY_LVL ^ ACTIVE_LOW;

  // Counter steering; a release clears both counters so the next press starts fresh
  always_comb begin
    hold_clr_c = 1'b0;
    hold_ld_c  = 1'b0;
    hold_inc_c = 1'b0;
    rep_clr_c  = 1'b0;
    rep_ld_c   = 1'b0;
    rep_inc_c  = 1'b0;
    if (!pressed_c) begin
      hold_clr_c = 1'b1;
      rep_clr_c  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: hold_ld_c = 1'b1;
        ST_HOLD: begin
          hold_inc_c = !hold_term_c;
          rep_ld_c   = hold_term_c;
        end
        ST_LONG: begin
          rep_ld_c  = rep_term_c;
          rep_inc_c = !rep_term_c;
        end
        default: ;
      endcase
    end
    if (!REPEAT_EN) begin
      rep_clr_c = 1'b1;
    end
  end

  key_evt_timer #(.CNT_W(CNT_W), .TERM(LONG_MS)) u_hold_tmr (
    .CLK1K  (CLK1K),
    .RST    (RST),
    .clr    (hold_clr_c),
    .load   (hold_ld_c),
    .inc    (hold_inc_c),
    .term_c (hold_term_c)
  );

  key_evt_timer #(.CNT_W(CNT_W), .TERM(REPEAT_MS)) u_rep_tmr (
    .CLK1K  (CLK1K),
    .RST    (RST),
    .clr    (rep_clr_c),
    .load   (rep_ld_c),
    .inc    (rep_inc_c),
    .term_c (rep_term_c)
  );

  // State and event registers; release is tested first so it wins over any threshold
  always_ff @(posedge CLK1K or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      evt_q <= '0;
    end else begin
      evt_q <= '0;
      case (state)
        ST_IDLE: begin
          if (pressed_c) begin
            state       <= ST_HOLD;
            evt_q.press <= 1'b1;
            evt_q.held  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (!pressed_c) begin
            state       <= ST_IDLE;
            evt_q.rel   <= 1'b1;
            evt_q.click <= 1'b1;
          end else begin
            evt_q.held <= 1'b1;
            if (hold_term_c) begin
              state            <= ST_LONG;
              evt_q.long_press <= 1'b1;
            end
          end
        end
        ST_LONG: begin
          if (!pressed_c) begin
            state     <= ST_IDLE;
            evt_q.rel <= 1'b1;
          end else begin
            evt_q.held <= 1'b1;
            evt_q.rpt  <= REPEAT_EN && rep_term_c;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign kif.PRESS_PULSE   = evt_q.press;
  assign kif.RELEASE_PULSE = evt_q.rel;
  assign kif.CLICK_PULSE   = evt_q.click;
  assign kif.LONG_PRESS    = evt_q.long_press;
  assign kif.REPEAT_PULSE  = evt_q.rpt;
  assign kif.HELD          = evt_q.held;

endmodule

// File: tb/tb_key_event_gen.sv
// Scoreboard bench for key_event_gen: directed key waveforms, expected events queued with their cycle.
module tb_key_event_gen;

  logic CLK1K = 1'b0;
  logic RST;

  always #5 CLK1K = ~CLK1K;

  key_event_gen_if kif0 ();
  key_event_gen_if kif1 ();

  key_event_gen #(
    .ACTIVE_LOW(1'b1), .LONG_MS(10), .REPEAT_MS(4), .REPEAT_EN(1'b1), .CNT_W(11)
  ) dut0 (
    .CLK1K (CLK1K),
    .RST   (RST),
    .kif   (kif0.master)
  );

  key_event_gen #(
    .ACTIVE_LOW(1'b1), .LONG_MS(10), .REPEAT_MS(4), .REPEAT_EN(1'b0), .CNT_W(11)
  ) dut1 (
    .CLK1K (CLK1K),
    .RST   (RST),
    .kif   (kif1.master)
  );

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  localparam logic [4:0] EV_PRESS = 5'b10000;
  localparam logic [4:0] EV_REL   = 5'b01000;
  localparam logic [4:0] EV_CLICK = 5'b00100;
  localparam logic [4:0] EV_LONG  = 5'b00010;
  localparam logic [4:0] EV_RPT   = 5'b00001;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge CLK1K) cyc <= cyc + 1;

  function automatic logic [4:0] evts(input int which);
    if (which == 0)
      return {kif0.PRESS_PULSE, kif0.RELEASE_PULSE, kif0.CLICK_PULSE, kif0.LONG_PRESS, kif0.REPEAT_PULSE};
    return {kif1.PRESS_PULSE, kif1.RELEASE_PULSE, kif1.CLICK_PULSE, kif1.LONG_PRESS, kif1.REPEAT_PULSE};
  endfunction

  function automatic logic [5:0] outs(input int which);
    return {evts(which), (which == 0) ? kif0.HELD : kif1.HELD};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (cyc=%0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int which, input int c, input logic [4:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
  endtask

  // Pops the oldest expected event whenever a DUT shows any pulse
  task automatic mon(input int which, input logic [4:0] act);
    exp_t e;
    int   depth;
    if (act == 5'b0) return;
    depth = (which == 0) ? q0.size() : q1.size();
    checks++;
    if (depth == 0) begin
      failures++;
      $display("FAIL evt%0d unexpected: got cyc=%0d ev=%b, required no event", which, cyc, act);
      return;
    end
    e = (which == 0) ? q0.pop_front() : q1.pop_front();
    if (e.cyc != cyc || e.ev != act) begin
      failures++;
      $display("FAIL evt%0d: got cyc=%0d ev=%b, required cyc=%0d ev=%b", which, cyc, act, e.cyc, e.ev);
    end
  endtask

  always @(negedge CLK1K) begin
    if (RST === 1'b0) begin
      mon(0, evts(0));
      mon(1, evts(1));
    end
  end

  task automatic tick();
    @(posedge CLK1K);
    #1;
  endtask

  task automatic drive(input int which, input logic lvl, input int n);
    if (which == 0) kif0.KEY_LVL = lvl;
    else            kif1.KEY_LVL = lvl;
    repeat (n) tick();
  endtask

  int b;

  initial begin
    RST = 1'b1;
    kif0.KEY_LVL = 1'b1;
    kif1.KEY_LVL = 1'b1;
    repeat (3) tick();
    chk("reset_outs0", 32'(outs(0)), 32'h0);
    chk("reset_outs1", 32'(outs(1)), 32'h0);
    RST = 1'b0;
    drive(0, 1'b1, 3);
    chk("idle_outs0", 32'(outs(0)), 32'h0);

    // short press: 5 cycles low
    b = cyc + 1;
    push(0, b, EV_PRESS);
    push(0, b + 5, EV_REL | EV_CLICK);
    drive(0, 1'b0, 5);
    chk("short_held", 32'(kif0.HELD), 32'h1);
    drive(0, 1'b1, 3);
    chk("short_unheld", 32'(kif0.HELD), 32'h0);

    // long hold: 25 cycles low
    b = cyc + 1;
    push(0, b, EV_PRESS);
    push(0, b + 10, EV_LONG);
    push(0, b + 14, EV_RPT);
    push(0, b + 18, EV_RPT);
    push(0, b + 22, EV_RPT);
    push(0, b + 25, EV_REL);
    drive(0, 1'b0, 25);
    chk("long_held", 32'(kif0.HELD), 32'h1);
    drive(0, 1'b1, 3);

    // release sampled exactly at the long threshold
    b = cyc + 1;
    push(0, b, EV_PRESS);
    push(0, b + 10, EV_REL | EV_CLICK);
    drive(0, 1'b0, 10);
    drive(0, 1'b1, 3);

    // release sampled exactly at the repeat threshold
    b = cyc + 1;
    push(0, b, EV_PRESS);
    push(0, b + 10, EV_LONG);
    push(0, b + 14, EV_REL);
    drive(0, 1'b0, 14);
    drive(0, 1'b1, 3);

    // minimum press followed immediately by another press
    b = cyc + 1;
    push(0, b, EV_PRESS);
    push(0, b + 1, EV_REL | EV_CLICK);
    push(0, b + 2, EV_PRESS);
    push(0, b + 5, EV_REL | EV_CLICK);
    drive(0, 1'b0, 1);
    drive(0, 1'b1, 1);
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 3);

    // reset during LONG, right on the first repeat pulse
    b = cyc + 1;
    push(0, b, EV_PRESS);
    push(0, b + 10, EV_LONG);
    drive(0, 1'b0, 15);
    chk("pre_rst_outs", 32'(outs(0)), 32'h03);
    RST = 1'b1;
    #1;
    chk("rst_async_outs", 32'(outs(0)), 32'h0);
    tick();
    tick();
    chk("rst_hold_outs", 32'(outs(0)), 32'h0);
    RST = 1'b0;
    b = cyc + 1;
    push(0, b, EV_PRESS);
    push(0, b + 10, EV_LONG);
    push(0, b + 11, EV_REL);
    drive(0, 1'b0, 11);
    drive(0, 1'b1, 3);

    // repeat disabled: 30-cycle hold on the second instance
    b = cyc + 1;
    push(1, b, EV_PRESS);
    push(1, b + 10, EV_LONG);
    push(1, b + 30, EV_REL);
    kif1.KEY_LVL = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("norpt_held", 32'(kif1.HELD), 32'h1);
    end
    kif1.KEY_LVL = 1'b1;
    tick();
    chk("norpt_unheld", 32'(kif1.HELD), 32'h0);
    repeat (4) tick();

    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
